div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Control-side front end for the iterative 32-bit divider (DIV/DIVU).
//  Takes a one-cycle start pulse and rs/rt operands from the main control unit.
//  Converts signed operands to magnitudes, then drives the divider's load/enable and operands.
//  Counts the divider's fixed iteration latency, applies sign correction and writes HI/LO.
//  Raises busy (stall), done and divide-by-zero to control.
// PARAMETERS
//  DIV_CYCLES  33  cycles div_ctrl is held high (32 iterations + 1 result-write cycle)
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  reset         in   1   asynchronous, active-high reset
//  start         in   1   one-cycle request from control; sampled only in IDLE
//  is_unsigned   in   1   1 = DIVU, 0 = DIV (signed); sampled with start
//  dividendo     in   32  dividend (rs); sampled with start
//  divisor       in   32  divisor (rt); sampled with start
//  div_hi        in   32  remainder magnitude from divider
//  div_lo        in   32  quotient magnitude from divider
//  div_load      out  1   one-cycle strobe: divider reinitialises from div_dividendo/div_divisor
//  div_ctrl      out  1   divider iterate enable
//  div_dividendo out  32  dividend magnitude to divider, stable LOAD..FIX
//  div_divisor   out  32  divisor magnitude to divider, stable LOAD..FIX
//  busy          out  1   operation in progress; control stalls mfhi/mflo/new div
//  done          out  1   one-cycle pulse: HI/LO valid (or div_zero flagged)
//  div_zero      out  1   one-cycle pulse with done when divisor == 0
//  HI            out  32  remainder register
//  LO            out  32  quotient register
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, counter=0, HI=LO=0, all strobes 0, operand outs 0.
//  FSM states: IDLE, LOAD, RUN, FIX, DONE.
//  IDLE: busy=0. start=1 & divisor==0 -> DONE with div_zero flag set; HI/LO unchanged.
//        start=1 & divisor!=0 -> latch magnitudes and signs -> LOAD.
//        Magnitude: signed and operand[31]=1 -> two's-complement negate; else unchanged.
//  LOAD: busy=1, div_load=1 for exactly this cycle, counter<=0 -> RUN.
//  RUN: busy=1, div_ctrl=1. Counter increments each cycle.
//       counter==DIV_CYCLES-1 -> FIX. div_ctrl is low in every other state.
//  FIX: busy=1; sample div_hi/div_lo and sign-correct:
//       LO = (signed & sgn_a^sgn_b) ? -div_lo : div_lo;
//       HI = (signed & sgn_a) ? -div_hi : div_hi.
//       HI/LO registered at end of FIX -> DONE.
//  DONE: busy=0, done=1 (div_zero=1 if zero path) for one cycle -> IDLE.
//  Latency: start sampled at edge 0 -> done high in cycle DIV_CYCLES+3 (36 at default).
//           Zero-divisor path: done in cycle 1.
//  start while busy (LOAD/RUN/FIX) or in DONE: ignored, no queuing.
//  Overflow 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0; no flag.
//  Width rule: all arithmetic is 32-bit modulo; negate = ~x+1.
//  Reset mid-RUN: divider enable drops immediately; HI/LO cleared; no done pulse.
//  HI/LO hold their last values between operations.
// TESTING
//  DIVU 100/7 -> LO=14, HI=2; done in cycle 36; busy high cycles 1..35.
//  DIV -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//  DIV 7/0 -> done & div_zero in cycle 1; HI/LO keep prior values; div_load never pulses.
//  DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
//  start re-pulsed during RUN -> ignored; single done at cycle 36.
//  Async reset at cycle 20 of RUN -> outputs 0 with no clock edge.
//  After reset, a fresh DIVU 9/3 yields LO=3, HI=0.

Source files
------------

// File: rtl/div_sequencer.sv
// Control front end for the iterative 32-bit divider: converts DIV/DIVU operands to
// magnitudes, sequences load/iterate, applies sign correction and registers HI/LO.
module div_sequencer #(
    parameter int DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_unsigned,
    input  logic [31:0] dividendo,
    input  logic [31:0] divisor,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        div_load,
    output logic        div_ctrl,
    output logic [31:0] div_dividendo,
    output logic [31:0] div_divisor,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_signed;
    logic           r_sgn_a;
    logic           r_sgn_b;
    logic [31:0]    r_mag_a;
    logic [31:0]    r_mag_b;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;
    logic           r_busy;
    logic           r_load;
    logic           r_ctrl;
    logic           r_done;
    logic           r_zero;

    logic           w_sgn_a;
    logic           w_sgn_b;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    assign w_sgn_a = ~is_unsigned & dividendo[31];
    assign w_sgn_b = ~is_unsigned & divisor[31];

    // Sequencer FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_signed <= 1'b0;
            r_sgn_a  <= 1'b0;
            r_sgn_b  <= 1'b0;
            r_mag_a  <= 32'd0;
            r_mag_b  <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_load   <= 1'b0;
            r_ctrl   <= 1'b0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;
            r_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == 32'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_zero  <= 1'b1;
                        end else begin
                            r_signed <= ~is_unsigned;
                            r_sgn_a  <= w_sgn_a;
                            r_sgn_b  <= w_sgn_b;
                            r_mag_a  <= w_sgn_a ? neg32(dividendo) : dividendo;
                            r_mag_b  <= w_sgn_b ? neg32(divisor) : divisor;
                            r_state  <= S_LOAD;
                            r_busy   <= 1'b1;
                            r_load   <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_ctrl  <= 1'b1;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CW'(1'b1);
                    if (r_cnt == CW'(DIV_CYCLES - 1)) begin
                        r_ctrl  <= 1'b0;
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_FIX: begin
                    // Remainder takes the dividend's sign; quotient is negative when signs differ
                    r_lo    <= (r_signed & (r_sgn_a ^ r_sgn_b)) ? neg32(div_lo) : div_lo;
                    r_hi    <= (r_signed & r_sgn_a) ? neg32(div_hi) : div_hi;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ctrl  <= 1'b0;
                end
            endcase
        end
    end

    assign div_load      = r_load;
    assign div_ctrl      = r_ctrl;
    assign div_dividendo = r_mag_a;
    assign div_divisor   = r_mag_b;
    assign busy          = r_busy;
    assign done          = r_done;
    assign div_zero      = r_zero;
    assign HI            = r_hi;
    assign LO            = r_lo;
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: behavioural divider stub, cycle-window reference model
// checked every cycle, plus literal expectations for the key operations.
module tb_div_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_unsigned = 1'b0;
    logic [31:0] dividendo = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_load;
    logic        div_ctrl;
    logic [31:0] div_dividendo;
    logic [31:0] div_divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests = 0;
    int n_fail  = 0;

    div_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .is_unsigned(is_unsigned),
        .dividendo(dividendo), .divisor(divisor), .div_hi(div_hi), .div_lo(div_lo),
        .div_load(div_load), .div_ctrl(div_ctrl), .div_dividendo(div_dividendo),
        .div_divisor(div_divisor), .busy(busy), .done(done), .div_zero(div_zero),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Divider stand-in: results appear only after 32 enabled iterations since load
    logic [31:0] dv_a = 32'd0, dv_b = 32'd0;
    int          dv_cnt = 0;
    always @(posedge clk) begin
        if (div_load) begin
            dv_a   <= div_dividendo;
            dv_b   <= div_divisor;
            dv_cnt <= 0;
        end else if (div_ctrl) begin
            dv_cnt <= dv_cnt + 1;
        end
    end
    assign div_lo = (dv_cnt >= 32 && dv_b != 32'd0) ? dv_a / dv_b : 32'hDEAD_BEEF;
    assign div_hi = (dv_cnt >= 32 && dv_b != 32'd0) ? dv_a % dv_b : 32'hDEAD_BEEF;

    // Reference model: per-operation cycle windows and results from integer arithmetic
    int          cyc = 0;
    int          m_start = -1000;
    int          m_done_c = -1000;
    logic        m_zero = 1'b0;
    logic [31:0] m_hi_old = 32'd0, m_hi_new = 32'd0;
    logic [31:0] m_lo_old = 32'd0, m_lo_new = 32'd0;
    logic [31:0] m_mag_a = 32'd0, m_mag_b = 32'd0;
    logic        chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_start  = -1000;
        m_done_c = -1000;
        m_zero   = 1'b0;
        m_hi_old = 32'd0; m_hi_new = 32'd0;
        m_lo_old = 32'd0; m_lo_new = 32'd0;
        m_mag_a  = 32'd0; m_mag_b  = 32'd0;
    endtask

    task automatic model_edge();
        longint la, lb, q, r, ma, mb;
        if (!reset && start && cyc > m_done_c) begin
            m_hi_old = m_hi_new;
            m_lo_old = m_lo_new;
            if (divisor == 32'd0) begin
                m_zero   = 1'b1;
                m_start  = -1000;
                m_done_c = cyc + 1;
            end else begin
                la = is_unsigned ? longint'(dividendo) : longint'($signed(dividendo));
                lb = is_unsigned ? longint'(divisor)   : longint'($signed(divisor));
                q  = la / lb;
                r  = la % lb;
                ma = (la < 0) ? -la : la;
                mb = (lb < 0) ? -lb : lb;
                m_lo_new = q[31:0];
                m_hi_new = r[31:0];
                m_mag_a  = ma[31:0];
                m_mag_b  = mb[31:0];
                m_zero   = 1'b0;
                m_start  = cyc;
                m_done_c = cyc + 36;
            end
        end
        cyc++;
    endtask

    // Every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("busy",  {31'd0, busy},
                {31'd0, !m_zero && cyc >= m_start + 1 && cyc <= m_start + 35});
            chk("load",  {31'd0, div_load}, {31'd0, !m_zero && cyc == m_start + 1});
            chk("ctrl",  {31'd0, div_ctrl},
                {31'd0, !m_zero && cyc >= m_start + 2 && cyc <= m_start + 34});
            chk("done",  {31'd0, done}, {31'd0, cyc == m_done_c});
            chk("zero",  {31'd0, div_zero}, {31'd0, cyc == m_done_c && m_zero});
            chk("HI",    HI, (cyc >= m_done_c) ? m_hi_new : m_hi_old);
            chk("LO",    LO, (cyc >= m_done_c) ? m_lo_new : m_lo_old);
            chk("opA",   div_dividendo, m_mag_a);
            chk("opB",   div_divisor, m_mag_b);
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    int   d_k, b_n, l_n, d_n;
    logic z_s;

    // One operation: start pulse, then n observed cycles with optional re-pulses of start
    task automatic do_op(input logic u, input logic [31:0] a, input logic [31:0] b,
                         input int n, input int rp1, input int rp2);
        is_unsigned = u; dividendo = a; divisor = b; start = 1'b1;
        step();
        start = 1'b0; dividendo = ~a; divisor = ~b;
        d_k = -1; b_n = 0; l_n = 0; d_n = 0; z_s = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (done) begin
                d_n++;
                if (d_k < 0) d_k = k;
            end
            b_n += int'(busy);
            l_n += int'(div_load);
            z_s |= div_zero;
            start = (k == rp1 || k == rp2);
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_opA", div_dividendo, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        step();

        do_op(1'b1, 32'd100, 32'd7, 40, -1, -1);
        chk("divu100_7_LO", LO, 32'd14);
        chk("divu100_7_HI", HI, 32'd2);
        chk("divu_done_cycle", d_k, 36);
        chk("divu_busy_cycles", b_n, 35);
        chk("divu_load_count", l_n, 1);

        do_op(1'b0, 32'hFFFF_FFF9, 32'd2, 40, -1, -1);
        chk("div_m7_2_LO", LO, 32'hFFFF_FFFD);
        chk("div_m7_2_HI", HI, 32'hFFFF_FFFF);

        do_op(1'b0, 32'd7, 32'd0, 4, -1, -1);
        chk("zero_done_cycle", d_k, 1);
        chk("zero_flag", {31'd0, z_s}, 32'd1);
        chk("zero_load_count", l_n, 0);
        chk("zero_keep_LO", LO, 32'hFFFF_FFFD);
        chk("zero_keep_HI", HI, 32'hFFFF_FFFF);

        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 40, -1, -1);
        chk("ovf_LO", LO, 32'h8000_0000);
        chk("ovf_HI", HI, 32'd0);
        chk("ovf_no_zero", {31'd0, z_s}, 32'd0);

        do_op(1'b0, 32'd7, 32'hFFFF_FFFE, 40, 10, 36);
        chk("repulse_done_count", d_n, 1);
        chk("repulse_done_cycle", d_k, 36);
        chk("div_7_m2_LO", LO, 32'hFFFF_FFFD);
        chk("div_7_m2_HI", HI, 32'd1);

        do_op(1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 40, -1, -1);
        chk("div_m8_m3_LO", LO, 32'd2);
        chk("div_m8_m3_HI", HI, 32'hFFFF_FFFE);

        do_op(1'b1, 32'hFFFF_FFFF, 32'd16, 40, -1, -1);
        chk("divu_big_LO", LO, 32'h0FFF_FFFF);
        chk("divu_big_HI", HI, 32'd15);

        // Reset in the middle of RUN: outputs must clear without a clock edge
        do_op(1'b1, 32'd50, 32'd3, 19, -1, -1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_ctrl", {31'd0, div_ctrl}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_HI", HI, 32'd0);
        chk("midrst_LO", LO, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        model_reset();
        step();
        step();
        reset = 1'b0;
        step();

        do_op(1'b1, 32'd9, 32'd3, 40, -1, -1);
        chk("post_rst_LO", LO, 32'd3);
        chk("post_rst_HI", HI, 32'd0);
        chk("post_rst_done_count", d_n, 1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
